tl_c_mem_manager: RTL and testbench
===================================

// Module: tl_c_mem_manager
// PURPOSE
//  Single-client TileLink-C manager (slave end) with an internal backing store; the responder
//  for the rv64g_l1_dcache master ports. Serves A-channel Get/Put/Acquire and C-channel
//  Release(Data), and answers on D. Never probes (single client). One transaction in flight.
// PARAMETERS
//  MEM_BYTES  4096  backing store size in bytes; power of 2, >= 64; array of MEM_BYTES/8 x 64b
//  SINK_ID    0     constant driven on tl_d_sink_o (4b)
// PORTS
//  clk_i            in   1   clock
//  rst_ni           in   1   asynchronous active-low reset
//  tl_a_valid_i/ready_o  in/out 1;  a_opcode_i 3, a_param_i 3, a_size_i 4, a_source_i 4,
//                   a_address_i 64, a_mask_i 8, a_data_i 64, a_corrupt_i 1 (ignored)
//  tl_b_valid_o     out  1   tied 0; b_opcode/param/size/source/address/mask/data/corrupt_o tied 0
//  tl_b_ready_i     in   1   ignored
//  tl_c_valid_i/ready_o  in/out 1;  c_opcode_i 3, c_param_i 3, c_size_i 4, c_source_i 4,
//                   c_address_i 64, c_data_i 64, c_corrupt_i 1 (ignored)
//  tl_d_valid_o/ready_i  out/in 1;  d_opcode_o 3, d_param_o 2, d_size_o 4, d_source_o 4,
//                   d_sink_o 4, d_denied_o 1, d_data_o 64, d_corrupt_o 1 (always 0)
//  tl_e_valid_i/ready_o  in/out 1;  e_sink_i 4 (ignored)
// BEHAVIOUR
//  - Reset: state IDLE; tl_d_valid_o=0, tl_e_ready_o=0, d fields 0; memory contents not reset.
//  - Beats: beats = (size<=3) ? 1 : 2^(size-3); size>6 clamps to 8. Beat index is a 3b counter;
//    beat address = {addr[63:6] , (addr[5:3] + idx) wrapped within the 2^size-aligned block}.
//    Memory word index = beat_addr[log2(MEM_BYTES)-1:3] (wraps modulo MEM_BYTES).
//  - FSM IDLE: c_ready_o=1; a_ready_o=!tl_c_valid_i (C has priority, guarantees Release progress).
//    Opcodes latched with size/source/address/param on first-beat handshake.
//    C Release(6)      -> D_RESP (single ReleaseAck).
//    C ReleaseData(7)  -> write beat 0, C_DATA if beats>1 else D_RESP.
//    C ProbeAck(4/5)   -> dropped (accepted, no response; unreachable since no probes issued).
//    A Put(0/1)        -> write beat 0 under mask (byte enables), A_DATA if beats>1 else D_RESP.
//    A Get(4)/Acquire(6/7) -> D_RESP. Other A opcodes -> D_RESP with AccessAck, denied=1.
//  - A_DATA / C_DATA: matching ready_o=1, other channel ready 0; each handshake writes one beat
//    (C writes full 8 bytes, A honours a_mask_i); after last beat -> D_RESP.
//  - D_RESP: d_valid_o=1 the cycle after the last A/C beat handshake. Response mapping:
//    Put->AccessAck(0); Get->AccessAckData(1); AcquireBlock->GrantData(5); AcquirePerm->Grant(4);
//    Release(Data)->ReleaseAck(6). Dataless responses are one beat; data responses stream `beats`
//    beats, d_data_o = mem[beat word] read combinationally, idx advances on d handshake only.
//    d_param: Grant/GrantData: NtoB(0)->toB(1), NtoT(1)/BtoT(2)->toT(0); others 0.
//    d_size/d_source echo request. D fields held stable while d_valid_o && !d_ready_i.
//    After final D beat: Grant/GrantData -> WAIT_E; else -> IDLE.
//  - WAIT_E: e_ready_o=1, a/c ready 0; e handshake -> IDLE. Next A/C accepted one cycle later.
//  - Writes to the same word in one cycle cannot occur (single transaction).
//  - Reset mid-operation: all in-flight state discarded, partial Put/ReleaseData beats already
//    written remain in memory.
// CONFIGURATION
//  TL_MGR_RANGE_CHECK_EN defined: request with address >= MEM_BYTES -> writes suppressed, data
//  responses return 0 with d_denied_o=1 on every beat; Grants still await GrantAck.
//  Undefined: no check, address wraps modulo MEM_BYTES, d_denied_o=0 except illegal opcode.
// TESTING
//  1 Put size=3 addr 0x40 data 0x1122334455667788 mask 0xFF, then Get size=3 0x40 -> AccessAck,
//    then AccessAckData data 0x1122334455667788, d_size=3, source echoed.
//  2 AcquireBlock param NtoT size=6 addr 0x80 (preloaded 0..7) -> 8 GrantData beats d_param=0
//    data 0..7 in order; a_ready_o=0 until E beat accepted.
//  3 ReleaseData size=6 addr 0x100 beats 0xA0..0xA7 with d_ready_i held 0 for 3 cycles ->
//    single ReleaseAck held stable, then Get size=6 returns 0xA0..0xA7.
//  4 a_valid and c_valid asserted same cycle in IDLE -> C accepted first, A accepted after
//    ReleaseAck handshake.
//  5 Put size=3 mask 0x0F onto 0xFFFF...FF -> readback 0xFFFFFFFF_xxxxxxxx with low 4 bytes new.
//  6 TL_MGR_RANGE_CHECK_EN, Get addr MEM_BYTES -> AccessAckData denied=1 data 0; rst_ni low
//    mid-GrantData -> d_valid_o=0 immediately, IDLE after release.

Source files
------------

// File: rtl/tl_c_mem_manager.sv
// Single-client TileLink-C manager with an internal backing store; one transaction in flight.
// Optional: define TL_MGR_RANGE_CHECK_EN to deny/suppress accesses at or above MEM_BYTES.
module tl_c_mem_manager #(
  parameter int unsigned MEM_BYTES = 4096,
  parameter logic [3:0]  SINK_ID   = 4'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // A channel
  input  logic        tl_a_valid_i,
  output logic        tl_a_ready_o,
  input  logic [2:0]  tl_a_opcode_i,
  input  logic [2:0]  tl_a_param_i,
  input  logic [3:0]  tl_a_size_i,
  input  logic [3:0]  tl_a_source_i,
  input  logic [63:0] tl_a_address_i,
  input  logic [7:0]  tl_a_mask_i,
  input  logic [63:0] tl_a_data_i,
  input  logic        tl_a_corrupt_i,
  // B channel
  output logic        tl_b_valid_o,
  input  logic        tl_b_ready_i,
  output logic [2:0]  tl_b_opcode_o,
  output logic [1:0]  tl_b_param_o,
  output logic [3:0]  tl_b_size_o,
  output logic [3:0]  tl_b_source_o,
  output logic [63:0] tl_b_address_o,
  output logic [7:0]  tl_b_mask_o,
  output logic [63:0] tl_b_data_o,
  output logic        tl_b_corrupt_o,
  // C channel
  input  logic        tl_c_valid_i,
  output logic        tl_c_ready_o,
  input  logic [2:0]  tl_c_opcode_i,
  input  logic [2:0]  tl_c_param_i,
  input  logic [3:0]  tl_c_size_i,
  input  logic [3:0]  tl_c_source_i,
  input  logic [63:0] tl_c_address_i,
  input  logic [63:0] tl_c_data_i,
  input  logic        tl_c_corrupt_i,
  // D channel
  output logic        tl_d_valid_o,
  input  logic        tl_d_ready_i,
  output logic [2:0]  tl_d_opcode_o,
  output logic [1:0]  tl_d_param_o,
  output logic [3:0]  tl_d_size_o,
  output logic [3:0]  tl_d_source_o,
  output logic [3:0]  tl_d_sink_o,
  output logic        tl_d_denied_o,
  output logic [63:0] tl_d_data_o,
  output logic        tl_d_corrupt_o,
  // E channel
  input  logic        tl_e_valid_i,
  output logic        tl_e_ready_o,
  input  logic [3:0]  tl_e_sink_i
);

  localparam int unsigned AW    = $clog2(MEM_BYTES);
  localparam int unsigned IW    = AW - 3;
  localparam int unsigned WORDS = MEM_BYTES / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_A_DATA,
    S_C_DATA,
    S_D_RESP,
    S_WAIT_E
  } state_e;

  // Beat count minus one; doubles as the wrap mask for the beat index within the block.
  function automatic logic [2:0] beat_mask(input logic [3:0] size);
    case (size)
      4'd0, 4'd1, 4'd2, 4'd3: return 3'd0;
      4'd4:                   return 3'd1;
      4'd5:                   return 3'd3;
      default:                return 3'd7;
    endcase
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [63:0] addr, input logic [2:0] bm,
                                             input logic [2:0] idx);
    logic [2:0]  w;
    logic [63:0] baddr;
    w     = (addr[5:3] & ~bm) | ((addr[5:3] + idx) & bm);
    baddr = {addr[63:6], w, addr[2:0]};
    return baddr[AW-1:3];
  endfunction

  function automatic logic [1:0] grant_param(input logic [2:0] p);
    return (p == 3'd0) ? 2'd1 : 2'd0;
  endfunction

  logic [63:0] mem_q [WORDS];

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  bm_q, bm_d;
  logic [3:0]  size_q, size_d;
  logic [3:0]  source_q, source_d;
  logic [63:0] addr_q, addr_d;
  logic [2:0]  dop_q, dop_d;
  logic [1:0]  dparam_q, dparam_d;
  logic        denied_q, denied_d;
  logic        oob_q, oob_d;

  logic          a_oob, c_oob;
  logic          we;
  logic [IW-1:0] widx;
  logic [IW-1:0] beat_idx;
  logic [63:0]   wdata;
  logic [7:0]    wmask;
  logic          d_is_data, d_is_grant, d_last;

`ifdef TL_MGR_RANGE_CHECK_EN
  assign a_oob = |tl_a_address_i[63:AW];
  assign c_oob = |tl_c_address_i[63:AW];
`else
  assign a_oob = 1'b0;
  assign c_oob = 1'b0;
`endif

  assign beat_idx   = word_idx(addr_q, bm_q, idx_q);
  assign d_is_data  = (dop_q == 3'd1) || (dop_q == 3'd5);
  assign d_is_grant = (dop_q == 3'd4) || (dop_q == 3'd5);
  assign d_last     = !d_is_data || (idx_q == bm_q);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bm_d         = bm_q;
    size_d       = size_q;
    source_d     = source_q;
    addr_d       = addr_q;
    dop_d        = dop_q;
    dparam_d     = dparam_q;
    denied_d     = denied_q;
    oob_d        = oob_q;
    tl_a_ready_o = 1'b0;
    tl_c_ready_o = 1'b0;
    tl_e_ready_o = 1'b0;
    we           = 1'b0;
    widx         = beat_idx;
    wdata        = '0;
    wmask        = '0;
    case (state_q)
      S_IDLE: begin
        tl_c_ready_o = 1'b1;
        tl_a_ready_o = !tl_c_valid_i;
        if (tl_c_valid_i) begin
          size_d   = tl_c_size_i;
          source_d = tl_c_source_i;
          addr_d   = tl_c_address_i;
          bm_d     = beat_mask(tl_c_size_i);
          dop_d    = 3'd6;
          dparam_d = 2'd0;
          oob_d    = c_oob;
          denied_d = c_oob;
          idx_d    = 3'd0;
          if (tl_c_opcode_i == 3'd6) begin
            state_d = S_D_RESP;
          end else if (tl_c_opcode_i == 3'd7) begin
            we    = !c_oob;
            widx  = word_idx(tl_c_address_i, beat_mask(tl_c_size_i), 3'd0);
            wdata = tl_c_data_i;
            wmask = '1;
            if (beat_mask(tl_c_size_i) != 3'd0) begin
              state_d = S_C_DATA;
              idx_d   = 3'd1;
            end else begin
              state_d = S_D_RESP;
            end
          end
        end else if (tl_a_valid_i) begin
          size_d   = tl_a_size_i;
          source_d = tl_a_source_i;
          addr_d   = tl_a_address_i;
          bm_d     = beat_mask(tl_a_size_i);
          dparam_d = 2'd0;
          oob_d    = a_oob;
          denied_d = a_oob;
          idx_d    = 3'd0;
          state_d  = S_D_RESP;
          case (tl_a_opcode_i)
            3'd0, 3'd1: begin
              dop_d = 3'd0;
              we    = !a_oob;
              widx  = word_idx(tl_a_address_i, beat_mask(tl_a_size_i), 3'd0);
              wdata = tl_a_data_i;
              wmask = tl_a_mask_i;
              if (beat_mask(tl_a_size_i) != 3'd0) begin
                state_d = S_A_DATA;
                idx_d   = 3'd1;
              end
            end
            3'd4: dop_d = 3'd1;
            3'd6: begin
              dop_d    = 3'd5;
              dparam_d = grant_param(tl_a_param_i);
            end
            3'd7: begin
              dop_d    = 3'd4;
              dparam_d = grant_param(tl_a_param_i);
            end
            default: begin
              dop_d    = 3'd0;
              denied_d = 1'b1;
            end
          endcase
        end
      end
      S_A_DATA: begin
        tl_a_ready_o = 1'b1;
        if (tl_a_valid_i) begin
          we    = !oob_q;
          wdata = tl_a_data_i;
          wmask = tl_a_mask_i;
          if (idx_q == bm_q) begin
            state_d = S_D_RESP;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_C_DATA: begin
        tl_c_ready_o = 1'b1;
        if (tl_c_valid_i) begin
          we    = !oob_q;
          wdata = tl_c_data_i;
          wmask = '1;
          if (idx_q == bm_q) begin
            state_d = S_D_RESP;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_D_RESP: begin
        if (tl_d_ready_i) begin
          if (d_last) begin
            idx_d   = 3'd0;
            state_d = d_is_grant ? S_WAIT_E : S_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_WAIT_E: begin
        tl_e_ready_o = 1'b1;
        if (tl_e_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tl_d_valid_o   = (state_q == S_D_RESP);
    tl_d_opcode_o  = '0;
    tl_d_param_o   = '0;
    tl_d_size_o    = '0;
    tl_d_source_o  = '0;
    tl_d_denied_o  = 1'b0;
    tl_d_data_o    = '0;
    tl_d_corrupt_o = 1'b0;
    tl_d_sink_o    = SINK_ID;
    if (tl_d_valid_o) begin
      tl_d_opcode_o = dop_q;
      tl_d_param_o  = dparam_q;
      tl_d_size_o   = size_q;
      tl_d_source_o = source_q;
      tl_d_denied_o = denied_q;
      if (d_is_data && !oob_q) tl_d_data_o = mem_q[beat_idx];
    end
  end

  assign tl_b_valid_o   = 1'b0;
  assign tl_b_opcode_o  = '0;
  assign tl_b_param_o   = '0;
  assign tl_b_size_o    = '0;
  assign tl_b_source_o  = '0;
  assign tl_b_address_o = '0;
  assign tl_b_mask_o    = '0;
  assign tl_b_data_o    = '0;
  assign tl_b_corrupt_o = 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      bm_q     <= '0;
      size_q   <= '0;
      source_q <= '0;
      addr_q   <= '0;
      dop_q    <= '0;
      dparam_q <= '0;
      denied_q <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bm_q     <= bm_d;
      size_q   <= size_d;
      source_q <= source_d;
      addr_q   <= addr_d;
      dop_q    <= dop_d;
      dparam_q <= dparam_d;
      denied_q <= denied_d;
      oob_q    <= oob_d;
    end
  end

  // Backing store is deliberately not reset; partial bursts survive a mid-transaction reset.
  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (wmask[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{tl_a_corrupt_i, tl_c_corrupt_i, tl_c_param_i, tl_b_ready_i,
                           tl_e_sink_i, addr_q, tl_a_address_i, tl_c_address_i};

endmodule

// File: tb/tb_tl_c_mem_manager.sv
// Directed scoreboard bench for tl_c_mem_manager: expected D beats queued at stimulus time.
module tb_tl_c_mem_manager;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        tl_a_valid_i = 1'b0, tl_a_ready_o;
  logic [2:0]  tl_a_opcode_i = '0, tl_a_param_i = '0;
  logic [3:0]  tl_a_size_i = '0, tl_a_source_i = '0;
  logic [63:0] tl_a_address_i = '0, tl_a_data_i = '0;
  logic [7:0]  tl_a_mask_i = '0;
  logic        tl_a_corrupt_i = 1'b0;
  logic        tl_b_valid_o, tl_b_ready_i = 1'b0;
  logic [2:0]  tl_b_opcode_o;
  logic [1:0]  tl_b_param_o;
  logic [3:0]  tl_b_size_o, tl_b_source_o;
  logic [63:0] tl_b_address_o, tl_b_data_o;
  logic [7:0]  tl_b_mask_o;
  logic        tl_b_corrupt_o;
  logic        tl_c_valid_i = 1'b0, tl_c_ready_o;
  logic [2:0]  tl_c_opcode_i = '0, tl_c_param_i = '0;
  logic [3:0]  tl_c_size_i = '0, tl_c_source_i = '0;
  logic [63:0] tl_c_address_i = '0, tl_c_data_i = '0;
  logic        tl_c_corrupt_i = 1'b0;
  logic        tl_d_valid_o, tl_d_ready_i = 1'b0;
  logic [2:0]  tl_d_opcode_o;
  logic [1:0]  tl_d_param_o;
  logic [3:0]  tl_d_size_o, tl_d_source_o, tl_d_sink_o;
  logic        tl_d_denied_o, tl_d_corrupt_o;
  logic [63:0] tl_d_data_o;
  logic        tl_e_valid_i = 1'b0, tl_e_ready_o;
  logic [3:0]  tl_e_sink_i = '0;

  tl_c_mem_manager #(.MEM_BYTES(4096), .SINK_ID(4'd0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .tl_a_valid_i(tl_a_valid_i), .tl_a_ready_o(tl_a_ready_o), .tl_a_opcode_i(tl_a_opcode_i),
    .tl_a_param_i(tl_a_param_i), .tl_a_size_i(tl_a_size_i), .tl_a_source_i(tl_a_source_i),
    .tl_a_address_i(tl_a_address_i), .tl_a_mask_i(tl_a_mask_i), .tl_a_data_i(tl_a_data_i),
    .tl_a_corrupt_i(tl_a_corrupt_i),
    .tl_b_valid_o(tl_b_valid_o), .tl_b_ready_i(tl_b_ready_i), .tl_b_opcode_o(tl_b_opcode_o),
    .tl_b_param_o(tl_b_param_o), .tl_b_size_o(tl_b_size_o), .tl_b_source_o(tl_b_source_o),
    .tl_b_address_o(tl_b_address_o), .tl_b_mask_o(tl_b_mask_o), .tl_b_data_o(tl_b_data_o),
    .tl_b_corrupt_o(tl_b_corrupt_o),
    .tl_c_valid_i(tl_c_valid_i), .tl_c_ready_o(tl_c_ready_o), .tl_c_opcode_i(tl_c_opcode_i),
    .tl_c_param_i(tl_c_param_i), .tl_c_size_i(tl_c_size_i), .tl_c_source_i(tl_c_source_i),
    .tl_c_address_i(tl_c_address_i), .tl_c_data_i(tl_c_data_i), .tl_c_corrupt_i(tl_c_corrupt_i),
    .tl_d_valid_o(tl_d_valid_o), .tl_d_ready_i(tl_d_ready_i), .tl_d_opcode_o(tl_d_opcode_o),
    .tl_d_param_o(tl_d_param_o), .tl_d_size_o(tl_d_size_o), .tl_d_source_o(tl_d_source_o),
    .tl_d_sink_o(tl_d_sink_o), .tl_d_denied_o(tl_d_denied_o), .tl_d_data_o(tl_d_data_o),
    .tl_d_corrupt_o(tl_d_corrupt_o),
    .tl_e_valid_i(tl_e_valid_i), .tl_e_ready_o(tl_e_ready_o), .tl_e_sink_i(tl_e_sink_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  param;
    logic [3:0]  size;
    logic [3:0]  src;
    logic        denied;
    logic [63:0] data;
  } dexp_t;

  dexp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [1:0] prm, input logic [3:0] sz,
                      input logic [3:0] src, input logic den, input logic [63:0] dat);
    dexp_t e;
    e.op = op; e.param = prm; e.size = sz; e.src = src; e.denied = den; e.data = dat;
    sb.push_back(e);
  endtask

  task automatic a_send(input logic [2:0] op, input logic [2:0] prm, input logic [3:0] sz,
                        input logic [3:0] src, input logic [63:0] addr, input logic [7:0] msk,
                        input logic [63:0] dat);
    int n = 0;
    tl_a_opcode_i = op; tl_a_param_i = prm; tl_a_size_i = sz; tl_a_source_i = src;
    tl_a_address_i = addr; tl_a_mask_i = msk; tl_a_data_i = dat; tl_a_valid_i = 1'b1;
    #1;
    while (!tl_a_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
    if (n >= 50) chk("a_ready_timeout", 64'd0, 64'd1);
    @(posedge clk_i); #1;
    tl_a_valid_i = 1'b0;
  endtask

  task automatic c_send(input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src,
                        input logic [63:0] addr, input logic [63:0] dat);
    int n = 0;
    tl_c_opcode_i = op; tl_c_size_i = sz; tl_c_source_i = src;
    tl_c_address_i = addr; tl_c_data_i = dat; tl_c_valid_i = 1'b1;
    #1;
    while (!tl_c_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
    if (n >= 50) chk("c_ready_timeout", 64'd0, 64'd1);
    @(posedge clk_i); #1;
    tl_c_valid_i = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input dexp_t e);
    chk({tag, "_opcode"}, 64'(tl_d_opcode_o), 64'(e.op));
    chk({tag, "_param"},  64'(tl_d_param_o),  64'(e.param));
    chk({tag, "_size"},   64'(tl_d_size_o),   64'(e.size));
    chk({tag, "_source"}, 64'(tl_d_source_o), 64'(e.src));
    chk({tag, "_denied"}, 64'(tl_d_denied_o), 64'(e.denied));
    chk({tag, "_data"},   tl_d_data_o,        e.data);
  endtask

  task automatic d_drain(input string tag, input int nbeats, input int stall);
    dexp_t e;
    for (int b = 0; b < nbeats; b++) begin
      int n = 0;
      while (!tl_d_valid_o && n < 100) begin @(posedge clk_i); #1; n++; end
      if (n >= 100) begin
        chk({tag, "_d_valid_timeout"}, 64'd0, 64'd1);
        return;
      end
      if (sb.size() == 0) begin
        chk({tag, "_sb_underflow"}, 64'd1, 64'd0);
        return;
      end
      e = sb.pop_front();
      if (b == 0) begin
        for (int s = 0; s < stall; s++) begin
          chk_beat({tag, "_stall"}, e);
          chk({tag, "_stall_valid"}, 64'(tl_d_valid_o), 64'd1);
          @(posedge clk_i); #1;
        end
      end
      chk_beat(tag, e);
      tl_d_ready_i = 1'b1;
      @(posedge clk_i); #1;
      tl_d_ready_i = 1'b0;
    end
  endtask

  task automatic e_send();
    tl_e_valid_i = 1'b1;
    #1;
    chk("e_ready", 64'(tl_e_ready_o), 64'd1);
    @(posedge clk_i); #1;
    tl_e_valid_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_d_valid", 64'(tl_d_valid_o), 64'd0);
    chk("rst_e_ready", 64'(tl_e_ready_o), 64'd0);
    chk("rst_d_opcode", 64'(tl_d_opcode_o), 64'd0);
    chk("rst_d_data", tl_d_data_o, 64'd0);
    chk("rst_b_valid", 64'(tl_b_valid_o), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("idle_a_ready", 64'(tl_a_ready_o), 64'd1);
    chk("idle_c_ready", 64'(tl_c_ready_o), 64'd1);

    // Put then Get single word
    a_send(3'd0, 3'd0, 4'd3, 4'd1, 64'h40, 8'hFF, 64'h1122334455667788);
    push(3'd0, 2'd0, 4'd3, 4'd1, 1'b0, 64'd0);
    d_drain("put40", 1, 0);
    a_send(3'd4, 3'd0, 4'd3, 4'd2, 64'h40, 8'h00, 64'd0);
    push(3'd1, 2'd0, 4'd3, 4'd2, 1'b0, 64'h1122334455667788);
    d_drain("get40", 1, 0);

    // Preload 0..7 at 0x80 with an 8-beat Put, then AcquireBlock NtoT
    for (int i = 0; i < 8; i++) a_send(3'd0, 3'd0, 4'd6, 4'd3, 64'h80, 8'hFF, 64'(i));
    push(3'd0, 2'd0, 4'd6, 4'd3, 1'b0, 64'd0);
    d_drain("put80", 1, 0);
    a_send(3'd6, 3'd1, 4'd6, 4'd4, 64'h80, 8'hFF, 64'd0);
    for (int i = 0; i < 8; i++) push(3'd5, 2'd0, 4'd6, 4'd4, 1'b0, 64'(i));
    d_drain("grantdata", 8, 0);
    tl_a_valid_i = 1'b1;
    #1;
    chk("wait_e_a_ready", 64'(tl_a_ready_o), 64'd0);
    tl_a_valid_i = 1'b0;
    e_send();
    chk("post_e_a_ready", 64'(tl_a_ready_o), 64'd1);

    // AcquirePerm NtoB -> Grant toB
    a_send(3'd7, 3'd0, 4'd6, 4'd5, 64'hC0, 8'hFF, 64'd0);
    push(3'd4, 2'd1, 4'd6, 4'd5, 1'b0, 64'd0);
    d_drain("grant", 1, 0);
    e_send();

    // Get starting mid-block wraps within the 64B block
    a_send(3'd4, 3'd0, 4'd6, 4'd6, 64'h98, 8'h00, 64'd0);
    for (int i = 0; i < 8; i++) push(3'd1, 2'd0, 4'd6, 4'd6, 1'b0, 64'((i + 3) % 8));
    d_drain("get_wrap", 8, 0);

    // ReleaseData with stalled ReleaseAck, then readback
    for (int i = 0; i < 8; i++) c_send(3'd7, 4'd6, 4'd7, 64'h100, 64'hA0 + 64'(i));
    push(3'd6, 2'd0, 4'd6, 4'd7, 1'b0, 64'd0);
    d_drain("releaseack", 1, 3);
    a_send(3'd4, 3'd0, 4'd6, 4'd8, 64'h100, 8'h00, 64'd0);
    for (int i = 0; i < 8; i++) push(3'd1, 2'd0, 4'd6, 4'd8, 1'b0, 64'hA0 + 64'(i));
    d_drain("get100", 8, 0);

    // A and C valid together: C wins, A waits for ReleaseAck
    tl_a_opcode_i = 3'd4; tl_a_param_i = 3'd0; tl_a_size_i = 4'd3; tl_a_source_i = 4'd9;
    tl_a_address_i = 64'h40; tl_a_valid_i = 1'b1;
    tl_c_opcode_i = 3'd6; tl_c_size_i = 4'd6; tl_c_source_i = 4'd10;
    tl_c_address_i = 64'h100; tl_c_valid_i = 1'b1;
    #1;
    chk("prio_c_ready", 64'(tl_c_ready_o), 64'd1);
    chk("prio_a_ready", 64'(tl_a_ready_o), 64'd0);
    @(posedge clk_i); #1;
    tl_c_valid_i = 1'b0;
    chk("prio_a_blocked", 64'(tl_a_ready_o), 64'd0);
    push(3'd6, 2'd0, 4'd6, 4'd10, 1'b0, 64'd0);
    d_drain("prio_rel", 1, 0);
    chk("prio_a_ready_after", 64'(tl_a_ready_o), 64'd1);
    @(posedge clk_i); #1;
    tl_a_valid_i = 1'b0;
    push(3'd1, 2'd0, 4'd3, 4'd9, 1'b0, 64'h1122334455667788);
    d_drain("prio_get", 1, 0);

    // Partial-mask Put over all-ones
    a_send(3'd0, 3'd0, 4'd3, 4'd1, 64'h48, 8'hFF, 64'hFFFFFFFFFFFFFFFF);
    push(3'd0, 2'd0, 4'd3, 4'd1, 1'b0, 64'd0);
    d_drain("put48_ones", 1, 0);
    a_send(3'd1, 3'd0, 4'd3, 4'd1, 64'h48, 8'h0F, 64'h0123456789ABCDEF);
    push(3'd0, 2'd0, 4'd3, 4'd1, 1'b0, 64'd0);
    d_drain("put48_mask", 1, 0);
    a_send(3'd4, 3'd0, 4'd3, 4'd2, 64'h48, 8'h00, 64'd0);
    push(3'd1, 2'd0, 4'd3, 4'd2, 1'b0, 64'hFFFFFFFF89ABCDEF);
    d_drain("get48", 1, 0);

    // Illegal opcode: denied AccessAck, no write
    a_send(3'd2, 3'd0, 4'd3, 4'd11, 64'h40, 8'hFF, 64'hDEADBEEFDEADBEEF);
    push(3'd0, 2'd0, 4'd3, 4'd11, 1'b1, 64'd0);
    d_drain("illegal", 1, 0);
    a_send(3'd4, 3'd0, 4'd3, 4'd2, 64'h40, 8'h00, 64'd0);
    push(3'd1, 2'd0, 4'd3, 4'd2, 1'b0, 64'h1122334455667788);
    d_drain("get40_after_illegal", 1, 0);

`ifdef TL_MGR_RANGE_CHECK_EN
    a_send(3'd4, 3'd0, 4'd3, 4'd12, 64'd4096, 8'h00, 64'd0);
    push(3'd1, 2'd0, 4'd3, 4'd12, 1'b1, 64'd0);
    d_drain("get_oob", 1, 0);
`else
    a_send(3'd4, 3'd0, 4'd3, 4'd12, 64'h1040, 8'h00, 64'd0);
    push(3'd1, 2'd0, 4'd3, 4'd12, 1'b0, 64'h1122334455667788);
    d_drain("get_alias", 1, 0);
`endif

    // Reset in the middle of a GrantData burst
    a_send(3'd6, 3'd2, 4'd6, 4'd13, 64'h80, 8'hFF, 64'd0);
    push(3'd5, 2'd0, 4'd6, 4'd13, 1'b0, 64'd0);
    push(3'd5, 2'd0, 4'd6, 4'd13, 1'b0, 64'd1);
    d_drain("grant_rst", 2, 0);
    chk("pre_rst_d_valid", 64'(tl_d_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_d_valid", 64'(tl_d_valid_o), 64'd0);
    chk("rst_mid_e_ready", 64'(tl_e_ready_o), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("post_rst_a_ready", 64'(tl_a_ready_o), 64'd1);
    chk("post_rst_d_valid", 64'(tl_d_valid_o), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
